// File: rtl/scoreboard_mc_if.sv
// Issue / flush / writeback bundle for scoreboard_mc.
// master: issue stage side (drives issue, flush and writeback; observes stalls).
// slave : scoreboard side (observes issue, flush and writeback; drives stalls).
//   issue_valid, issue_rs_valid[3], issue_rs_class[3], issue_rs[3]   - source operands
//   issue_rd_valid, issue_rd_class, issue_rd                         - destination
//   stall, stall_raw, stall_waw                                      - combinational hold
//   flush_valid, flush_rd_class, flush_rd                            - squash one issue
//   wb_valid[NUM_WB], wb_class[NUM_WB], wb_rd[NUM_WB]                - writeback ports
interface scoreboard_mc_if #(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned NUM_WB   = 3
) ();
    localparam int unsigned IW = $clog2(NUM_REGS);

    logic                         issue_valid;
    logic [2:0]                   issue_rs_valid;
    logic [2:0][1:0]              issue_rs_class;
    logic [2:0][IW-1:0]           issue_rs;
    logic                         issue_rd_valid;
    logic [1:0]                   issue_rd_class;
    logic [IW-1:0]                issue_rd;
    logic                         stall;
    logic                         stall_raw;
    logic                         stall_waw;
    logic                         flush_valid;
    logic [1:0]                   flush_rd_class;
    logic [IW-1:0]                flush_rd;
    logic [NUM_WB-1:0]            wb_valid;
    logic [NUM_WB-1:0][1:0]       wb_class;
    logic [NUM_WB-1:0][IW-1:0]    wb_rd;

    modport master (
        output issue_valid, issue_rs_valid, issue_rs_class, issue_rs,
        output issue_rd_valid, issue_rd_class, issue_rd,
        output flush_valid, flush_rd_class, flush_rd,
        output wb_valid, wb_class, wb_rd,
        input  stall, stall_raw, stall_waw
    );

    modport slave (
        input  issue_valid, issue_rs_valid, issue_rs_class, issue_rs,
        input  issue_rd_valid, issue_rd_class, issue_rd,
        input  flush_valid, flush_rd_class, flush_rd,
        input  wb_valid, wb_class, wb_rd,
        output stall, stall_raw, stall_waw
    );
endinterface

// File: rtl/scoreboard_mc.sv
// Multi-class register scoreboard with saturating per-register in-flight write counters.
// Ports:
//   clk, rst_n     - clock, synchronous active-low reset
//   sb (slave)     - issue / flush / writeback bundle, stall outputs (see scoreboard_mc_if)
//   idle           - registered, every counter is zero
//   err_underflow  - sticky, some decrement found nothing left to retire
module scoreboard_mc #(
    parameter int unsigned NUM_CLASSES = 3,
    parameter int unsigned NUM_REGS    = 32,
    parameter int unsigned CNT_W       = 2,
    parameter int unsigned NUM_WB      = 3,
    parameter bit          ALLOW_WAW   = 1'b1,
    parameter bit          ZERO_X0     = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    scoreboard_mc_if.slave sb,
    output logic           idle,
    output logic           err_underflow
);
    localparam int unsigned IW    = $clog2(NUM_REGS);
    localparam int unsigned DEC_W = $clog2(NUM_WB + 2);
    // Wide enough for cnt + inc and for the worst-case decrement count.
    localparam int unsigned SW    = ((CNT_W + 1 > DEC_W) ? CNT_W + 1 : DEC_W) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Out-of-range class indices alias onto the last implemented class.
    function automatic logic [1:0] map_class(input logic [1:0] c);
        if (32'(c) >= NUM_CLASSES) return 2'(NUM_CLASSES - 1);
        return c;
    endfunction

    function automatic logic is_x0(input int k, input int j);
        return ZERO_X0 && (k == 0) && (j == 0);
    endfunction

    logic [CNT_W-1:0] cnt_q [NUM_CLASSES][NUM_REGS];
    logic [CNT_W-1:0] cnt_d [NUM_CLASSES][NUM_REGS];
    logic             idle_q, idle_d;
    logic             err_q, err_d;

    logic [1:0]              rd_cls;
    logic [1:0]              fl_cls;
    logic [2:0][1:0]         rs_cls;
    logic [NUM_WB-1:0][1:0]  wb_cls;
    logic [CNT_W-1:0]        rd_cnt;
    logic [2:0]              rs_busy;
    logic                    rd_is_x0;
    logic                    raw;
    logic                    waw;
    logic                    accept;

    always_comb begin
        rd_cls = map_class(sb.issue_rd_class);
        fl_cls = map_class(sb.flush_rd_class);
        rs_cls = '0;
        wb_cls = '0;
        for (int s = 0; s < 3; s++) rs_cls[s] = map_class(sb.issue_rs_class[s]);
        for (int p = 0; p < NUM_WB; p++) wb_cls[p] = map_class(sb.wb_class[p]);
    end

    // Look up the current counters for rd and the three sources.
    always_comb begin
        rd_cnt  = '0;
        rs_busy = '0;
        for (int k = 0; k < NUM_CLASSES; k++) begin
            for (int j = 0; j < NUM_REGS; j++) begin
                if (rd_cls == 2'(k) && sb.issue_rd == IW'(j)) rd_cnt = cnt_q[k][j];
                for (int s = 0; s < 3; s++) begin
                    if (rs_cls[s] == 2'(k) && sb.issue_rs[s] == IW'(j) &&
                        cnt_q[k][j] != '0 && !is_x0(k, j)) begin
                        rs_busy[s] = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        raw      = sb.issue_valid & (|(sb.issue_rs_valid & rs_busy));
        waw      = sb.issue_valid & sb.issue_rd_valid &
                   ((!ALLOW_WAW && rd_cnt != '0) || rd_cnt == CNT_MAX);
        rd_is_x0 = ZERO_X0 && rd_cls == 2'd0 && sb.issue_rd == '0;
        accept   = sb.issue_valid & ~(raw | waw) & sb.issue_rd_valid & ~rd_is_x0;
        sb.stall_raw = raw;
        sb.stall_waw = waw;
        sb.stall     = raw | waw;
    end

    // Net arithmetic per register: one increment from issue against any number of
    // writeback/flush decrements in the same cycle.
    always_comb begin
        err_d  = err_q;
        idle_d = 1'b1;
        for (int k = 0; k < NUM_CLASSES; k++) begin
            for (int j = 0; j < NUM_REGS; j++) begin
                logic          inc;
                logic [SW-1:0] dec;
                logic [SW-1:0] sum;
                inc = accept && rd_cls == 2'(k) && sb.issue_rd == IW'(j);
                dec = '0;
                for (int p = 0; p < NUM_WB; p++) begin
                    if (sb.wb_valid[p] && wb_cls[p] == 2'(k) && sb.wb_rd[p] == IW'(j)) begin
                        dec = dec + SW'(1);
                    end
                end
                if (sb.flush_valid && fl_cls == 2'(k) && sb.flush_rd == IW'(j)) begin
                    dec = dec + SW'(1);
                end
                sum = SW'(cnt_q[k][j]) + SW'(inc);
                if (is_x0(k, j)) begin
                    cnt_d[k][j] = '0;
                end else if (sum < dec) begin
                    cnt_d[k][j] = '0;
                    err_d       = 1'b1;
                end else begin
                    cnt_d[k][j] = CNT_W'(sum - dec);
                end
                if (cnt_d[k][j] != '0) idle_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_CLASSES; k++) begin
                for (int j = 0; j < NUM_REGS; j++) cnt_q[k][j] <= '0;
            end
            idle_q <= 1'b1;
            err_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            idle_q <= idle_d;
            err_q  <= err_d;
        end
    end

    assign idle          = idle_q;
    assign err_underflow = err_q;
endmodule

// File: tb/tb_scoreboard_mc.sv
module tb_scoreboard_mc;
    localparam int NR = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic            issue_valid;
    logic [2:0]      rs_valid;
    logic [2:0][1:0] rs_class;
    logic [2:0][4:0] rs;
    logic            rd_valid;
    logic [1:0]      rd_class;
    logic [4:0]      rd;
    logic            flush_valid;
    logic [1:0]      flush_class;
    logic [4:0]      flush_rd;
    logic [2:0]      wb_valid;
    logic [2:0][1:0] wb_class;
    logic [2:0][4:0] wb_rd;

    logic idle_w, err_w, idle_n, err_n;

    scoreboard_mc_if #(.NUM_REGS(NR), .NUM_WB(3)) if_w ();
    scoreboard_mc_if #(.NUM_REGS(NR), .NUM_WB(3)) if_n ();

    scoreboard_mc #(.ALLOW_WAW(1'b1)) dut_w (
        .clk(clk), .rst_n(rst_n), .sb(if_w), .idle(idle_w), .err_underflow(err_w)
    );
    scoreboard_mc #(.ALLOW_WAW(1'b0)) dut_n (
        .clk(clk), .rst_n(rst_n), .sb(if_n), .idle(idle_n), .err_underflow(err_n)
    );

    assign if_w.issue_valid    = issue_valid;
    assign if_w.issue_rs_valid = rs_valid;
    assign if_w.issue_rs_class = rs_class;
    assign if_w.issue_rs       = rs;
    assign if_w.issue_rd_valid = rd_valid;
    assign if_w.issue_rd_class = rd_class;
    assign if_w.issue_rd       = rd;
    assign if_w.flush_valid    = flush_valid;
    assign if_w.flush_rd_class = flush_class;
    assign if_w.flush_rd       = flush_rd;
    assign if_w.wb_valid       = wb_valid;
    assign if_w.wb_class       = wb_class;
    assign if_w.wb_rd          = wb_rd;
    assign if_n.issue_valid    = issue_valid;
    assign if_n.issue_rs_valid = rs_valid;
    assign if_n.issue_rs_class = rs_class;
    assign if_n.issue_rs       = rs;
    assign if_n.issue_rd_valid = rd_valid;
    assign if_n.issue_rd_class = rd_class;
    assign if_n.issue_rd       = rd;
    assign if_n.flush_valid    = flush_valid;
    assign if_n.flush_rd_class = flush_class;
    assign if_n.flush_rd       = flush_rd;
    assign if_n.wb_valid       = wb_valid;
    assign if_n.wb_class       = wb_class;
    assign if_n.wb_rd          = wb_rd;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: index 0 = WAW allowed, index 1 = busy rd stalls.
    int cnt [2][3][NR];
    bit m_err [2];
    bit m_idle [2];
    bit armed = 1'b0;

    function automatic int cls(input logic [1:0] c);
        return (int'(c) >= 3) ? 2 : int'(c);
    endfunction

    function automatic bit is_x0(input logic [1:0] c, input logic [4:0] r);
        return cls(c) == 0 && r == 5'd0;
    endfunction

    function automatic int cnt_of(input int m, input logic [1:0] c, input logic [4:0] r);
        if (is_x0(c, r)) return 0;
        return cnt[m][cls(c)][r];
    endfunction

    function automatic void want_stall(input int m, output bit raw, output bit waw);
        int c;
        raw = 1'b0;
        waw = 1'b0;
        if (issue_valid) begin
            for (int s = 0; s < 3; s++) begin
                if (rs_valid[s] && cnt_of(m, rs_class[s], rs[s]) > 0) raw = 1'b1;
            end
            if (rd_valid) begin
                c   = cnt_of(m, rd_class, rd);
                waw = (c == 3) || (m == 1 && c > 0);
            end
        end
    endfunction

    task automatic model_step();
        bit raw, waw;
        int delta [3][NR];
        int v;
        for (int m = 0; m < 2; m++) begin
            if (rst_n !== 1'b1) begin
                for (int c = 0; c < 3; c++) for (int r = 0; r < NR; r++) cnt[m][c][r] = 0;
                m_err[m]  = 1'b0;
                m_idle[m] = 1'b1;
            end else begin
                want_stall(m, raw, waw);
                for (int c = 0; c < 3; c++) for (int r = 0; r < NR; r++) delta[c][r] = 0;
                if (issue_valid && !raw && !waw && rd_valid && !is_x0(rd_class, rd))
                    delta[cls(rd_class)][rd] += 1;
                for (int p = 0; p < 3; p++) begin
                    if (wb_valid[p] && !is_x0(wb_class[p], wb_rd[p]))
                        delta[cls(wb_class[p])][wb_rd[p]] -= 1;
                end
                if (flush_valid && !is_x0(flush_class, flush_rd))
                    delta[cls(flush_class)][flush_rd] -= 1;
                m_idle[m] = 1'b1;
                for (int c = 0; c < 3; c++) begin
                    for (int r = 0; r < NR; r++) begin
                        v = cnt[m][c][r] + delta[c][r];
                        if (v < 0) begin
                            v        = 0;
                            m_err[m] = 1'b1;
                        end
                        cnt[m][c][r] = v;
                        if (v != 0) m_idle[m] = 1'b0;
                    end
                end
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: compare every output to the model mid-cycle, then advance the model.
    task automatic cycle();
        bit raw, waw;
        @(negedge clk);
        if (armed) begin
            want_stall(0, raw, waw);
            check("w_stall_raw", 32'(if_w.stall_raw), 32'(raw));
            check("w_stall_waw", 32'(if_w.stall_waw), 32'(waw));
            check("w_stall", 32'(if_w.stall), 32'(raw | waw));
            check("w_idle", 32'(idle_w), 32'(m_idle[0]));
            check("w_err", 32'(err_w), 32'(m_err[0]));
            want_stall(1, raw, waw);
            check("n_stall_raw", 32'(if_n.stall_raw), 32'(raw));
            check("n_stall_waw", 32'(if_n.stall_waw), 32'(waw));
            check("n_stall", 32'(if_n.stall), 32'(raw | waw));
            check("n_idle", 32'(idle_n), 32'(m_idle[1]));
            check("n_err", 32'(err_n), 32'(m_err[1]));
        end
        model_step();
        @(posedge clk);
        #1;
        if (!rst_n) armed = 1'b1;
    endtask

    task automatic clr();
        issue_valid = 1'b0;
        rs_valid    = '0;
        rd_valid    = 1'b0;
        flush_valid = 1'b0;
        wb_valid    = '0;
    endtask

    task automatic iss(input logic v, input logic [1:0] c, input logic [4:0] r);
        clr();
        issue_valid = 1'b1;
        rd_valid    = v;
        rd_class    = c;
        rd          = r;
    endtask

    task automatic src(input int s, input logic [1:0] c, input logic [4:0] r);
        rs_valid[s] = 1'b1;
        rs_class[s] = c;
        rs[s]       = r;
    endtask

    task automatic wb(input int p, input logic [1:0] c, input logic [4:0] r);
        wb_valid[p] = 1'b1;
        wb_class[p] = c;
        wb_rd[p]    = r;
    endtask

    task automatic do_reset();
        clr();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n       = 1'b0;
        rs_class    = '0;
        rs          = '0;
        rd_class    = '0;
        rd          = '0;
        flush_class = '0;
        flush_rd    = '0;
        wb_class    = '0;
        wb_rd       = '0;
        clr();
        cycle();
        cycle();
        rst_n = 1'b1;
        #1 check("rst_idle", 32'(idle_w), 32'd1);
        check("rst_err", 32'(err_w), 32'd0);

        // RAW on s5, released by writeback one cycle later.
        iss(1'b1, 2'd0, 5'd5);
        cycle();
        iss(1'b0, 2'd0, 5'd0);
        src(0, 2'd0, 5'd5);
        #1 check("raw_s5_stall", 32'(if_w.stall), 32'd1);
        check("raw_s5_raw", 32'(if_w.stall_raw), 32'd1);
        cycle();
        wb(0, 2'd0, 5'd5);
        #1 check("raw_s5_no_bypass", 32'(if_w.stall), 32'd1);
        cycle();
        wb_valid = '0;
        #1 check("raw_s5_freed", 32'(if_w.stall), 32'd0);
        check("raw_s5_idle", 32'(idle_w), 32'd1);
        cycle();
        clr();
        cycle();

        // Saturation on f3, then triple writeback.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            iss(1'b1, 2'd1, 5'd3);
            cycle();
        end
        iss(1'b1, 2'd1, 5'd3);
        #1 check("sat_f3_waw", 32'(if_w.stall_waw), 32'd1);
        check("sat_f3_idle", 32'(idle_w), 32'd0);
        cycle();
        clr();
        wb(0, 2'd1, 5'd3);
        wb(1, 2'd1, 5'd3);
        wb(2, 2'd1, 5'd3);
        cycle();
        clr();
        #1 check("sat_f3_drain_idle", 32'(idle_w), 32'd1);
        check("sat_f3_drain_err", 32'(err_w), 32'd0);
        cycle();

        // Same-cycle issue + writeback on v7; class 3 aliases to vector.
        do_reset();
        iss(1'b1, 2'd2, 5'd7);
        cycle();
        iss(1'b1, 2'd2, 5'd7);
        wb(0, 2'd2, 5'd7);
        #1 check("v7_waw_allowed", 32'(if_w.stall), 32'd0);
        check("v7_waw_blocked", 32'(if_n.stall_waw), 32'd1);
        cycle();
        iss(1'b0, 2'd0, 5'd0);
        src(2, 2'd3, 5'd7);
        #1 check("v7_rs3_raw", 32'(if_w.stall_raw), 32'd1);
        check("v7_rs3_free_n", 32'(if_n.stall), 32'd0);
        cycle();

        // Flush retires one issue; a stray writeback sets the sticky error.
        do_reset();
        iss(1'b1, 2'd0, 5'd9);
        cycle();
        clr();
        flush_valid = 1'b1;
        flush_class = 2'd0;
        flush_rd    = 5'd9;
        cycle();
        clr();
        #1 check("flush_err", 32'(err_w), 32'd0);
        check("flush_idle", 32'(idle_w), 32'd1);
        wb(1, 2'd0, 5'd9);
        cycle();
        clr();
        #1 check("uflow_err", 32'(err_w), 32'd1);
        cycle();
        cycle();
        check("uflow_sticky", 32'(err_w), 32'd1);
        check("uflow_idle", 32'(idle_w), 32'd1);

        // Scalar x0 is never tracked; fp reg 0 is.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            iss(1'b1, 2'd0, 5'd0);
            src(0, 2'd0, 5'd0);
            src(1, 2'd0, 5'd0);
            #1 check("x0_stall", 32'(if_w.stall), 32'd0);
            check("x0_idle", 32'(idle_w), 32'd1);
            cycle();
        end
        iss(1'b1, 2'd1, 5'd0);
        cycle();
        iss(1'b0, 2'd0, 5'd0);
        src(0, 2'd1, 5'd0);
        #1 check("f0_tracked", 32'(if_w.stall_raw), 32'd1);
        cycle();

        // Reset in the middle of traffic.
        do_reset();
        iss(1'b1, 2'd0, 5'd1);
        cycle();
        iss(1'b1, 2'd0, 5'd1);
        cycle();
        iss(1'b1, 2'd2, 5'd4);
        cycle();
        iss(1'b1, 2'd0, 5'd1);
        wb(0, 2'd2, 5'd4);
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        iss(1'b0, 2'd0, 5'd0);
        src(0, 2'd0, 5'd1);
        src(1, 2'd2, 5'd4);
        #1 check("mid_rst_stall", 32'(if_w.stall), 32'd0);
        check("mid_rst_idle", 32'(idle_w), 32'd1);
        check("mid_rst_err", 32'(err_w), 32'd0);
        cycle();

        // Random traffic on a few registers so hazards and collisions are common.
        for (int i = 0; i < 400; i++) begin
            rst_n       = ($urandom_range(0, 79) != 0);
            issue_valid = ($urandom_range(0, 3) != 0);
            rs_valid    = 3'($urandom);
            for (int s = 0; s < 3; s++) begin
                rs_class[s] = 2'($urandom);
                rs[s]       = 5'($urandom_range(0, 3));
            end
            rd_valid    = ($urandom_range(0, 3) != 0);
            rd_class    = 2'($urandom);
            rd          = 5'($urandom_range(0, 3));
            flush_valid = ($urandom_range(0, 5) == 0);
            flush_class = 2'($urandom);
            flush_rd    = 5'($urandom_range(0, 3));
            for (int p = 0; p < 3; p++) begin
                wb_valid[p] = ($urandom_range(0, 2) == 0);
                wb_class[p] = 2'($urandom);
                wb_rd[p]    = 5'($urandom_range(0, 3));
            end
            cycle();
        end
        clr();
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
